// File: rtl/game_score_timer.sv
// game_score_timer
//   Produces the game state for the 4-digit seven-segment display path.
//   A round counts down in packed BCD seconds. The score is a saturating BCD
//   counter driven by the hit and miss pulses. The block flags the end of the round.
//   Optional feature macro: HIGH_SCORE_EN (keeps the best score across rounds).
// Ports
//   clk_1k       in   1 kHz clock, all state moves on the rising edge
//   rst          in   synchronous reset, active-high, wins over every input
//   start        in   level, starts a round from IDLE or DONE
//   hit / miss   in   one-cycle pulses, +1 / -1 on the score while running
//   left_value   out  packed BCD seconds remaining
//   right_value  out  packed BCD score
//   running      out  high in RUN
//   game_over    out  high in DONE
//   high_score   out  packed BCD best score (8'h00 without HIGH_SCORE_EN)
//   new_record   out  1-cycle pulse when a round ends above the best score
module game_score_timer #(
    parameter int         TICKS_PER_SEC = 1000,
    parameter logic [7:0] GAME_SECONDS  = 8'h30
) (
    input  logic       clk_1k,
    input  logic       rst,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    output logic [7:0] left_value,
    output logic [7:0] right_value,
    output logic       running,
    output logic       game_over,
    output logic [7:0] high_score,
    output logic       new_record
);
    localparam int            TW        = $clog2(TICKS_PER_SEC);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        r_state, w_state_next;
    logic [TW-1:0] r_tick;
    logic [7:0]    r_left;
    logic [7:0]    r_score;
    logic [7:0]    w_score_next;
    logic          w_tick_wrap;
    logic          w_last_sec;
    logic          w_reload;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign w_tick_wrap = (r_state == S_RUN) && (r_tick == TICK_LAST);
    // The wrap that takes 01 to 00 ends the round on that same edge.
    assign w_last_sec  = w_tick_wrap && (r_left == 8'h01);
    assign w_reload    = (r_state != S_RUN) && start;

    always_comb begin
        w_state_next = r_state;
        w_score_next = r_score;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_state_next = S_RUN;
            S_RUN: begin
                if (w_last_sec) w_state_next = S_DONE;
                // hit and miss together cancel out. Both saturate at the ends.
                if (hit && !miss && r_score != 8'h99)
                    w_score_next = bcd_inc(r_score);
                else if (miss && !hit && r_score != 8'h00)
                    w_score_next = bcd_dec(r_score);
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_1k) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_left  <= GAME_SECONDS;
            r_score <= 8'h00;
            r_tick  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_reload) begin
                r_left  <= GAME_SECONDS;
                r_score <= 8'h00;
                r_tick  <= '0;
            end else if (r_state == S_RUN) begin
                r_score <= w_score_next;
                if (w_tick_wrap) begin
                    r_tick <= '0;
                    r_left <= bcd_dec(r_left);
                end else begin
                    r_tick <= r_tick + TW'(1);
                end
            end
        end
    end

    assign left_value  = r_left;
    assign right_value = r_score;
    assign running     = (r_state == S_RUN);
    assign game_over   = (r_state == S_DONE);

`ifdef HIGH_SCORE_EN
    logic [7:0] r_high;
    logic       r_new;

    // Valid BCD orders the same way as binary, so a plain compare works.
    always_ff @(posedge clk_1k) begin
        if (rst) begin
            r_high <= 8'h00;
            r_new  <= 1'b0;
        end else begin
            r_new <= 1'b0;
            if (w_last_sec && (w_score_next > r_high)) begin
                r_high <= w_score_next;
                r_new  <= 1'b1;
            end
        end
    end

    assign high_score = r_high;
    assign new_record = r_new;
`else
    assign high_score = 8'h00;
    assign new_record = 1'b0;
`endif
endmodule

// File: tb/tb_game_score_timer.sv
module tb_game_score_timer;
    logic clk_1k = 1'b0;
    logic rst = 1'b1, start = 1'b0, hit = 1'b0, miss = 1'b0;
    logic start9 = 1'b0, hit9 = 1'b0, miss9 = 1'b0;
    logic [7:0] lv, rv, hs, lv9, rv9, hs9;
    logic run, go, nr, run9, go9, nr9;

`ifdef HIGH_SCORE_EN
    localparam bit HSEN = 1'b1;
`else
    localparam bit HSEN = 1'b0;
`endif

    game_score_timer #(.TICKS_PER_SEC(4), .GAME_SECONDS(8'h03)) u_dut (
        .clk_1k(clk_1k), .rst(rst), .start(start), .hit(hit), .miss(miss),
        .left_value(lv), .right_value(rv), .running(run), .game_over(go),
        .high_score(hs), .new_record(nr));

    game_score_timer #(.TICKS_PER_SEC(4), .GAME_SECONDS(8'h99)) u_dut99 (
        .clk_1k(clk_1k), .rst(rst), .start(start9), .hit(hit9), .miss(miss9),
        .left_value(lv9), .right_value(rv9), .running(run9), .game_over(go9),
        .high_score(hs9), .new_record(nr9));

    always #5 clk_1k = ~clk_1k;

    typedef struct {
        string      name;
        int         cyc;
        bit         d9;
        bit         chk_l;
        logic [7:0] l, r;
        logic       run, go;
        logic [7:0] hs;
        logic       nr;
    } exp_t;

    exp_t q[$];
    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;

    // Hand-computed tables for the GAME_SECONDS=03 rounds (edges 1..12 after start)
    logic [7:0] a_l [12] = '{8'h03, 8'h03, 8'h03, 8'h02, 8'h02, 8'h02, 8'h02,
                             8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
    logic       b_h [12] = '{1, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 1};
    logic       b_m [12] = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    logic [7:0] b_r [12] = '{8'h01, 8'h02, 8'h02, 8'h03, 8'h02, 8'h03, 8'h04,
                             8'h04, 8'h04, 8'h04, 8'h04, 8'h05};
    logic       c_h [12] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    logic       c_m [12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [7:0] c_r [12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h03, 8'h03, 8'h03,
                             8'h03, 8'h03, 8'h03, 8'h03, 8'h03};
    logic [7:0] n_r [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                             8'h08, 8'h09, 8'h10, 8'h11, 8'h12};

    always @(posedge clk_1k) cyc <= cyc + 1;

    function automatic logic [7:0] hsx(input logic [7:0] v);
        return HSEN ? v : 8'h00;
    endfunction

    task automatic step(input logic r, input logic s, input logic h, input logic m);
        @(negedge clk_1k);
        rst = r; start = s; hit = h; miss = m;
        start9 = 1'b0; hit9 = 1'b0; miss9 = 1'b0;
    endtask

    task automatic step9(input logic s, input logic h, input logic m);
        @(negedge clk_1k);
        rst = 1'b0; start = 1'b0; hit = 1'b0; miss = 1'b0;
        start9 = s; hit9 = h; miss9 = m;
    endtask

    // Expectation for the outputs after the coming rising edge.
    task automatic expa(input string n, input logic [7:0] l, input logic [7:0] r,
                        input logic ru, input logic g, input logic [7:0] h, input logic x);
        exp_t e;
        e.name = n; e.cyc = cyc + 1; e.d9 = 1'b0; e.chk_l = 1'b1;
        e.l = l; e.r = r; e.run = ru; e.go = g; e.hs = h; e.nr = x;
        q.push_back(e);
    endtask

    task automatic exp9(input string n, input bit cl, input logic [7:0] l, input logic [7:0] r);
        exp_t e;
        e.name = n; e.cyc = cyc + 1; e.d9 = 1'b1; e.chk_l = cl;
        e.l = l; e.r = r; e.run = 1'b1; e.go = 1'b0; e.hs = 8'h00; e.nr = 1'b0;
        q.push_back(e);
    endtask

    // Monitor: pops every expectation due this cycle and compares.
    initial begin
        exp_t e;
        logic [7:0] gl, gr, gh;
        logic gru, ggo, gnr;
        forever begin
            @(negedge clk_1k);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                n_vec++;
                if (e.d9) begin
                    gl = lv9; gr = rv9; gru = run9; ggo = go9; gh = hs9; gnr = nr9;
                end else begin
                    gl = lv; gr = rv; gru = run; ggo = go; gh = hs; gnr = nr;
                end
                if (e.cyc != cyc || (e.chk_l && gl !== e.l) || gr !== e.r ||
                    gru !== e.run || ggo !== e.go || gh !== e.hs || gnr !== e.nr) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d got l=%h r=%h run=%b go=%b hs=%h nr=%b exp l=%h r=%h run=%b go=%b hs=%h nr=%b (due cyc %0d)",
                             e.name, cyc, gl, gr, gru, ggo, gh, gnr,
                             e.l, e.r, e.run, e.go, e.hs, e.nr, e.cyc);
                end
            end
        end
    end

    initial begin
        // reset and idle
        step(1, 0, 0, 0); expa("rst1", 8'h03, 8'h00, 0, 0, 8'h00, 0);
        step(1, 0, 0, 0); expa("rst2", 8'h03, 8'h00, 0, 0, 8'h00, 0);
        step(0, 0, 0, 0); expa("idle", 8'h03, 8'h00, 0, 0, 8'h00, 0);
        step(0, 0, 1, 0); expa("idle_hit", 8'h03, 8'h00, 0, 0, 8'h00, 0);

        // round A: plain countdown, start held mid-round is ignored
        step(0, 1, 0, 0); expa("a_start", 8'h03, 8'h00, 1, 0, 8'h00, 0);
        for (int i = 0; i < 12; i++) begin
            step(0, i == 4, 0, 0);
            expa($sformatf("a_cnt%0d", i + 1), a_l[i], 8'h00, i < 11, i == 11, 8'h00, 0);
        end
        step(0, 0, 1, 0); expa("a_done_hit", 8'h00, 8'h00, 0, 1, 8'h00, 0);

        // round B: hit+miss cancels, hit on final-tick edge counts, ends at 05
        step(0, 1, 0, 0); expa("b_start", 8'h03, 8'h00, 1, 0, 8'h00, 0);
        for (int i = 0; i < 12; i++) begin
            step(0, 0, b_h[i], b_m[i]);
            expa($sformatf("b_sc%0d", i + 1), a_l[i], b_r[i], i < 11, i == 11,
                 (i == 11) ? hsx(8'h05) : 8'h00, (i == 11) && HSEN);
        end
        step(0, 0, 1, 0); expa("b_done_hit", 8'h00, 8'h05, 0, 1, hsx(8'h05), 0);

        // round C: miss at 00 ignored, ends at 03 (no new record)
        step(0, 1, 0, 0); expa("c_start", 8'h03, 8'h00, 1, 0, hsx(8'h05), 0);
        for (int i = 0; i < 12; i++) begin
            step(0, 0, c_h[i], c_m[i]);
            expa($sformatf("c_sc%0d", i + 1), a_l[i], c_r[i], i < 11, i == 11, hsx(8'h05), 0);
        end
        step(0, 0, 0, 0); expa("c_done", 8'h00, 8'h03, 0, 1, hsx(8'h05), 0);

        // reset beats start and hit
        step(1, 1, 1, 0); expa("rst_prio", 8'h03, 8'h00, 0, 0, 8'h00, 0);
        step(0, 0, 0, 0); expa("post_rst", 8'h03, 8'h00, 0, 0, 8'h00, 0);

        // long round: BCD carry, miss, saturation at 99
        step9(1, 0, 0); exp9("s9_start", 1, 8'h99, 8'h00);
        for (int i = 0; i < 12; i++) begin
            step9(0, 1, 0); exp9($sformatf("s9_hit%0d", i + 1), 0, 8'h00, n_r[i]);
        end
        step9(0, 0, 1); exp9("s9_miss", 0, 8'h00, 8'h11);
        repeat (88) step9(0, 1, 0);
        step9(0, 0, 0); exp9("s9_at99", 0, 8'h00, 8'h99);
        step9(0, 1, 0); exp9("s9_sat", 0, 8'h00, 8'h99);
        step9(0, 1, 1); exp9("s9_hitmiss", 0, 8'h00, 8'h99);

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
